// File: rtl/bram_pkg.sv
// Shared types and helpers for the simple-dual-port block RAM.
package bram_pkg;

    // Controller state: zero-filling the array, or serving requests.
    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    // Read-during-write behaviour on a same-address collision.
    localparam int RDW_WRITE_FIRST = 0;
    localparam int RDW_READ_FIRST  = 1;

    // Number of byte lanes (write strobes) in one word.
    function automatic int strbWidth(input int dataWidth, input int byteWidth);
        return dataWidth / byteWidth;
    endfunction

endpackage

// File: rtl/bram_rdw_merge.sv
// Write-first forwarding mux: overlays the strobed lanes of a colliding
// write onto the word read from the array in the same cycle.
module bram_rdw_merge
    import bram_pkg::*;
#(
    parameter int dataWidth_p = 16,
    parameter int byteWidth_p = 8
) (
    input  logic [dataWidth_p-1:0]                            mem_data_i,
    input  logic                                              coll_i,
    input  logic [strbWidth(dataWidth_p, byteWidth_p)-1:0]    wstrb_i,
    input  logic [dataWidth_p-1:0]                            wdata_i,
    output logic [dataWidth_p-1:0]                            data_o
);

    localparam int STRB_W = strbWidth(dataWidth_p, byteWidth_p);

    // Pick each lane from the colliding write when its strobe was set.
    always_comb begin
        data_o = mem_data_i;
        if (coll_i) begin
            for (int k = 0; k < STRB_W; k++) begin
                if (wstrb_i[k]) begin
                    data_o[k*byteWidth_p +: byteWidth_p] = wdata_i[k*byteWidth_p +: byteWidth_p];
                end
            end
        end
    end

endmodule

// File: rtl/bram_sdp.sv
// Simple-dual-port block RAM: byte-strobed write port, independent read
// port, 1- or 2-cycle read latency, selectable read-during-write mode and
// a post-reset zero-fill sequencer.
module bram_sdp
    import bram_pkg::*;
#(
    parameter int memSize_p      = 8,
    parameter int dataWidth_p    = 16,
    parameter int byteWidth_p    = 8,
    parameter int outReg_p       = 0,
    parameter int rdwMode_p      = 0,
    parameter int clearOnReset_p = 1
) (
    input  logic                                              clk_i,
    input  logic                                              reset_i,
    input  logic                                              write_i,
    input  logic [memSize_p-1:0]                              waddr_i,
    input  logic [dataWidth_p-1:0]                            wdata_i,
    input  logic [strbWidth(dataWidth_p, byteWidth_p)-1:0]    wstrb_i,
    input  logic                                              read_i,
    input  logic [memSize_p-1:0]                              raddr_i,
    output logic [dataWidth_p-1:0]                            rdata_o,
    output logic                                              rvalid_o,
    output logic                                              busy_o
);

    localparam int DEPTH  = 2 ** memSize_p;
    localparam int STRB_W = strbWidth(dataWidth_p, byteWidth_p);

    if (dataWidth_p % byteWidth_p != 0) begin : g_bad_width
        $error("bram_sdp: dataWidth_p must be a multiple of byteWidth_p");
    end

    state_e                 state_q, state_d;
    logic [memSize_p-1:0]   cnt_q, cnt_d;
    logic                   rv1_q, rv1_d;

    logic                   mem_we;
    logic [memSize_p-1:0]   mem_addr;
    logic [dataWidth_p-1:0] mem_wdata;
    logic [STRB_W-1:0]      mem_strb;
    logic                   rd_en;

    logic [dataWidth_p-1:0] mem [DEPTH];
    logic [dataWidth_p-1:0] rd_word_q;
    logic [dataWidth_p-1:0] rd_merged;

    // Clear sequencer and request gating: the write port is borrowed by the
    // zero-fill while clearing, and user requests are dropped until READY.
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_we    = 1'b0;
        mem_addr  = waddr_i;
        mem_wdata = wdata_i;
        mem_strb  = wstrb_i;
        rd_en     = 1'b0;
        case (state_q)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_addr  = cnt_q;
                mem_wdata = '0;
                mem_strb  = '1;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == memSize_p'(DEPTH - 1)) begin
                    state_d = READY;
                end
            end
            READY: begin
                mem_we = write_i;
                rd_en  = read_i;
            end
            default: state_d = READY;
        endcase
        rv1_d = rd_en;
    end

    // Control registers; reset restarts the clear from address 0.
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= (clearOnReset_p != 0) ? CLEAR : READY;
            cnt_q   <= '0;
            rv1_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rv1_q   <= rv1_d;
        end
    end

    // Byte-strobed array write.
    // NOTE: the array has no reset so it maps onto block RAM; a known
    // initial state comes from the clear sequencer instead.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int k = 0; k < STRB_W; k++) begin
                if (mem_strb[k]) begin
                    mem[mem_addr][k*byteWidth_p +: byteWidth_p] <= mem_wdata[k*byteWidth_p +: byteWidth_p];
                end
            end
        end
    end

    // Synchronous array read; sees pre-write contents on a collision.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_word_q <= '0;
        end else if (rd_en) begin
            rd_word_q <= mem[raddr_i];
        end
    end

    if (rdwMode_p == RDW_WRITE_FIRST) begin : g_write_first
        logic                   coll_q, coll_d;
        logic [STRB_W-1:0]      wstrb_q, wstrb_d;
        logic [dataWidth_p-1:0] wdata_q, wdata_d;

        // Capture collision info alongside each accepted read; hold otherwise
        // so rdata_o keeps its last value between reads.
        always_comb begin
            coll_d  = coll_q;
            wstrb_d = wstrb_q;
            wdata_d = wdata_q;
            if (rd_en) begin
                coll_d  = mem_we && (waddr_i == raddr_i);
                wstrb_d = wstrb_i;
                wdata_d = wdata_i;
            end
        end

        // Collision side-band registers.
        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                coll_q  <= 1'b0;
                wstrb_q <= '0;
                wdata_q <= '0;
            end else begin
                coll_q  <= coll_d;
                wstrb_q <= wstrb_d;
                wdata_q <= wdata_d;
            end
        end

        bram_rdw_merge #(
            .dataWidth_p (dataWidth_p),
            .byteWidth_p (byteWidth_p)
        ) u_merge (
            .mem_data_i (rd_word_q),
            .coll_i     (coll_q),
            .wstrb_i    (wstrb_q),
            .wdata_i    (wdata_q),
            .data_o     (rd_merged)
        );
    end else begin : g_read_first
        assign rd_merged = rd_word_q;
    end

    if (outReg_p == 0) begin : g_lat1
        assign rdata_o  = rd_merged;
        assign rvalid_o = rv1_q;
    end else begin : g_lat2
        logic [dataWidth_p-1:0] dout_q, dout_d;
        logic                   rv2_q, rv2_d;

        // Second stage loads only when a result arrives.
        always_comb begin
            dout_d = rv1_q ? rd_merged : dout_q;
            rv2_d  = rv1_q;
        end

        // Output register.
        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                dout_q <= '0;
                rv2_q  <= 1'b0;
            end else begin
                dout_q <= dout_d;
                rv2_q  <= rv2_d;
            end
        end

        assign rdata_o  = dout_q;
        assign rvalid_o = rv2_q;
    end

    assign busy_o = (state_q == CLEAR);

endmodule

// File: tb/tb_bram_sdp.sv
// Self-checking bench: three bram_sdp configurations share one stimulus
// stream and are compared against a word-level reference model.
module tb_bram_sdp;

    localparam int N = 3;
    // dut 0: latency 1, write-first, clear; dut 1: latency 2, read-first,
    // clear; dut 2: latency 2, write-first, no clear.
    localparam int LAT [N] = '{1, 2, 2};
    localparam int RDW [N] = '{0, 1, 0};
    localparam bit CLR [N] = '{1'b1, 1'b1, 1'b0};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic [3:0]  waddr = '0;
    logic [3:0]  raddr = '0;
    logic [15:0] wdata = '0;
    logic [1:0]  wstrb = '0;

    logic [15:0] rdata_w [N];
    logic        rvalid_w [N];
    logic        busy_w [N];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bram_sdp #(.memSize_p(4), .dataWidth_p(16), .byteWidth_p(8),
               .outReg_p(0), .rdwMode_p(0), .clearOnReset_p(1)) dut_a (
        .clk_i(clk), .reset_i(rst), .write_i(write), .waddr_i(waddr),
        .wdata_i(wdata), .wstrb_i(wstrb), .read_i(read), .raddr_i(raddr),
        .rdata_o(rdata_w[0]), .rvalid_o(rvalid_w[0]), .busy_o(busy_w[0]));

    bram_sdp #(.memSize_p(4), .dataWidth_p(16), .byteWidth_p(8),
               .outReg_p(1), .rdwMode_p(1), .clearOnReset_p(1)) dut_b (
        .clk_i(clk), .reset_i(rst), .write_i(write), .waddr_i(waddr),
        .wdata_i(wdata), .wstrb_i(wstrb), .read_i(read), .raddr_i(raddr),
        .rdata_o(rdata_w[1]), .rvalid_o(rvalid_w[1]), .busy_o(busy_w[1]));

    bram_sdp #(.memSize_p(4), .dataWidth_p(16), .byteWidth_p(8),
               .outReg_p(1), .rdwMode_p(0), .clearOnReset_p(0)) dut_c (
        .clk_i(clk), .reset_i(rst), .write_i(write), .waddr_i(waddr),
        .wdata_i(wdata), .wstrb_i(wstrb), .read_i(read), .raddr_i(raddr),
        .rdata_o(rdata_w[2]), .rvalid_o(rvalid_w[2]), .busy_o(busy_w[2]));

    // Reference model: word array, known-word flags, remaining clear
    // cycles and a latency-deep queue of expected read results.
    logic [15:0] mdl [N][16];
    bit          known [N][16];
    int          clr_left [N];
    logic [15:0] s1_d [N];
    bit          s1_v [N];
    bit          s1_k [N];
    logic [15:0] e_d [N];
    bit          e_v [N];
    bit          e_k [N];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                clr_left[i] = CLR[i] ? 16 : 0;
                if (CLR[i]) begin
                    for (int a = 0; a < 16; a++) begin
                        mdl[i][a]   = 16'h0000;
                        known[i][a] = 1'b1;
                    end
                end
                s1_v[i] = 1'b0;
                s1_d[i] = 16'h0000;
                s1_k[i] = 1'b1;
                e_v[i]  = 1'b0;
                e_d[i]  = 16'h0000;
                e_k[i]  = 1'b1;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                logic [15:0] r;
                bit rk, rd, wr;
                rd = (clr_left[i] == 0) && read;
                wr = (clr_left[i] == 0) && write;
                r  = mdl[i][raddr];
                rk = known[i][raddr];
                if (rd && wr && (raddr == waddr) && RDW[i] == 0) begin
                    for (int l = 0; l < 2; l++)
                        if (wstrb[l]) r[l*8 +: 8] = wdata[l*8 +: 8];
                    if (wstrb == 2'b11) rk = 1'b1;
                end
                if (LAT[i] == 1) begin
                    e_v[i] = rd;
                    if (rd) begin e_d[i] = r; e_k[i] = rk; end
                end else begin
                    e_v[i] = s1_v[i];
                    if (s1_v[i]) begin e_d[i] = s1_d[i]; e_k[i] = s1_k[i]; end
                    s1_v[i] = rd;
                    if (rd) begin s1_d[i] = r; s1_k[i] = rk; end
                end
                if (wr) begin
                    for (int l = 0; l < 2; l++)
                        if (wstrb[l]) mdl[i][waddr][l*8 +: 8] = wdata[l*8 +: 8];
                    if (wstrb == 2'b11) known[i][waddr] = 1'b1;
                end
                if (clr_left[i] > 0) clr_left[i]--;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        write = 1'b0;
        read  = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        for (int i = 0; i < N; i++) begin
            checks++;
            if (rdata_w[i] !== 16'h0000) begin
                failures++;
                $display("FAIL reset_rdata dut%0d got=%h exp=0000", i, rdata_w[i]);
            end
            checks++;
            if (rvalid_w[i] !== 1'b0) begin
                failures++;
                $display("FAIL reset_rvalid dut%0d got=%0b exp=0", i, rvalid_w[i]);
            end
            checks++;
            if (busy_w[i] !== CLR[i]) begin
                failures++;
                $display("FAIL reset_busy dut%0d got=%0b exp=%0b", i, busy_w[i], CLR[i]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Zero-fill timing, dropped requests, no-clear first-cycle access.
    task automatic test_clear();
        int busy_cnt [N];
        busy_cnt = '{0, 0, 0};
        for (int cyc = 0; cyc < 36; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (busy_w[i] === 1'b1) busy_cnt[i]++;
                checks++;
                if (busy_w[i] !== (clr_left[i] != 0)) begin
                    failures++;
                    $display("FAIL clear_busy dut%0d cyc%0d got=%0b exp=%0b", i, cyc, busy_w[i], clr_left[i] != 0);
                end
                checks++;
                if (rvalid_w[i] !== e_v[i]) begin
                    failures++;
                    $display("FAIL clear_rvalid dut%0d cyc%0d got=%0b exp=%0b", i, cyc, rvalid_w[i], e_v[i]);
                end
                if (e_k[i]) begin
                    checks++;
                    if (rdata_w[i] !== e_d[i]) begin
                        failures++;
                        $display("FAIL clear_rdata dut%0d cyc%0d got=%h exp=%h", i, cyc, rdata_w[i], e_d[i]);
                    end
                end
            end
            if (cyc == 3) begin
                checks++;
                if (rvalid_w[2] !== 1'b1 || rdata_w[2] !== 16'h5A5A) begin
                    failures++;
                    $display("FAIL noclear_first got=%0b/%h exp=1/5a5a", rvalid_w[2], rdata_w[2]);
                end
            end
            if (cyc >= 17 && rvalid_w[0] === 1'b1) begin
                checks++;
                if (rdata_w[0] !== 16'h0000) begin
                    failures++;
                    $display("FAIL clear_zero cyc%0d got=%h exp=0000", cyc, rdata_w[0]);
                end
            end
            idle();
            if (cyc == 0) begin
                write = 1'b1; waddr = 4'd2; wdata = 16'h5A5A; wstrb = 2'b11;
            end else if (cyc == 1) begin
                read = 1'b1; raddr = 4'd2;
            end else if (cyc >= 3 && cyc < 16) begin
                write = 1'($urandom); waddr = 4'($urandom);
                wdata = 16'($urandom); wstrb = 2'($urandom);
                read = 1'($urandom); raddr = 4'($urandom);
            end else if (cyc >= 17 && cyc < 33) begin
                read = 1'b1; raddr = 4'(cyc - 17);
            end
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (busy_cnt[i] != 16) begin
                failures++;
                $display("FAIL clear_len dut%0d got=%0d exp=16", i, busy_cnt[i]);
            end
        end
        checks++;
        if (busy_cnt[2] != 0) begin
            failures++;
            $display("FAIL noclear_busy got=%0d exp=0", busy_cnt[2]);
        end
    endtask

    task automatic test_strobe();
        write = 1'b1; waddr = 4'd3; wdata = 16'hABCD; wstrb = 2'b11; tick();
        wdata = 16'h1200; wstrb = 2'b10; tick();
        idle(); read = 1'b1; raddr = 4'd3; tick();
        idle();
        checks++;
        if (rvalid_w[0] !== 1'b1 || rdata_w[0] !== 16'h12CD) begin
            failures++;
            $display("FAIL strobe_lat1 got=%0b/%h exp=1/12cd", rvalid_w[0], rdata_w[0]);
        end
        checks++;
        if (rvalid_w[1] !== 1'b0) begin
            failures++;
            $display("FAIL strobe_lat2_early got=%0b exp=0", rvalid_w[1]);
        end
        tick();
        for (int i = 1; i < N; i++) begin
            checks++;
            if (rvalid_w[i] !== 1'b1 || rdata_w[i] !== 16'h12CD) begin
                failures++;
                $display("FAIL strobe_lat2 dut%0d got=%0b/%h exp=1/12cd", i, rvalid_w[i], rdata_w[i]);
            end
        end
        checks++;
        if (rvalid_w[0] !== 1'b0 || rdata_w[0] !== 16'h12CD) begin
            failures++;
            $display("FAIL strobe_hold got=%0b/%h exp=0/12cd", rvalid_w[0], rdata_w[0]);
        end
    endtask

    task automatic test_collision();
        write = 1'b1; waddr = 4'd5; wdata = 16'h1111; wstrb = 2'b11; tick();
        wdata = 16'h2222; wstrb = 2'b01; read = 1'b1; raddr = 4'd5; tick();
        write = 1'b0;
        checks++;
        if (rdata_w[0] !== 16'h1122) begin
            failures++;
            $display("FAIL coll_write_first got=%h exp=1122", rdata_w[0]);
        end
        tick();
        idle();
        checks++;
        if (rdata_w[1] !== 16'h1111) begin
            failures++;
            $display("FAIL coll_read_first got=%h exp=1111", rdata_w[1]);
        end
        checks++;
        if (rdata_w[2] !== 16'h1122) begin
            failures++;
            $display("FAIL coll_write_first_lat2 got=%h exp=1122", rdata_w[2]);
        end
        checks++;
        if (rdata_w[0] !== 16'h1122) begin
            failures++;
            $display("FAIL coll_after_lat1 got=%h exp=1122", rdata_w[0]);
        end
        tick();
        checks++;
        if (rdata_w[1] !== 16'h1122 || rvalid_w[1] !== 1'b1) begin
            failures++;
            $display("FAIL coll_after_read_first got=%0b/%h exp=1/1122", rvalid_w[1], rdata_w[1]);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] v [4];
        for (int k = 0; k < 4; k++) begin
            v[k] = 16'($urandom);
            write = 1'b1; waddr = 4'(k); wdata = v[k]; wstrb = 2'b11; tick();
        end
        write = 1'b0;
        for (int j = 0; j < 6; j++) begin
            read = (j < 4); raddr = 4'(j);
            tick();
            checks++;
            if (j < 4) begin
                if (rvalid_w[0] !== 1'b1 || rdata_w[0] !== v[j]) begin
                    failures++;
                    $display("FAIL pipe_lat1 j%0d got=%0b/%h exp=1/%h", j, rvalid_w[0], rdata_w[0], v[j]);
                end
            end else if (rvalid_w[0] !== 1'b0) begin
                failures++;
                $display("FAIL pipe_lat1 j%0d got=%0b exp=0", j, rvalid_w[0]);
            end
            for (int i = 1; i < N; i++) begin
                checks++;
                if (j >= 1 && j <= 4) begin
                    if (rvalid_w[i] !== 1'b1 || rdata_w[i] !== v[j-1]) begin
                        failures++;
                        $display("FAIL pipe_lat2 dut%0d j%0d got=%0b/%h exp=1/%h", i, j, rvalid_w[i], rdata_w[i], v[j-1]);
                    end
                end else if (rvalid_w[i] !== 1'b0) begin
                    failures++;
                    $display("FAIL pipe_lat2 dut%0d j%0d got=%0b exp=0", i, j, rvalid_w[i]);
                end
            end
        end
        idle();
    endtask

    task automatic test_zero_strobe();
        write = 1'b1; waddr = 4'd7; wdata = 16'hBEEF; wstrb = 2'b11; tick();
        wdata = 16'h0000; wstrb = 2'b00; tick();
        idle(); read = 1'b1; raddr = 4'd7; tick();
        idle();
        checks++;
        if (rvalid_w[0] !== 1'b1 || rdata_w[0] !== 16'hBEEF) begin
            failures++;
            $display("FAIL zero_strobe got=%0b/%h exp=1/beef", rvalid_w[0], rdata_w[0]);
        end
        tick();
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            write = 1'($urandom); waddr = 4'($urandom);
            wdata = 16'($urandom); wstrb = 2'($urandom);
            read = 1'($urandom); raddr = ($urandom_range(0, 3) == 0) ? waddr : 4'($urandom);
            tick();
            for (int i = 0; i < N; i++) begin
                checks++;
                if (rvalid_w[i] !== e_v[i]) begin
                    failures++;
                    $display("FAIL rand_rvalid dut%0d cyc%0d got=%0b exp=%0b", i, cyc, rvalid_w[i], e_v[i]);
                end
                if (e_k[i]) begin
                    checks++;
                    if (rdata_w[i] !== e_d[i]) begin
                        failures++;
                        $display("FAIL rand_rdata dut%0d cyc%0d got=%h exp=%h", i, cyc, rdata_w[i], e_d[i]);
                    end
                end
            end
        end
        idle();
        tick();
        tick();
    endtask

    task automatic test_reset_mid_clear();
        int busy_cnt;
        write = 1'b1; waddr = 4'd9; wdata = 16'hC3A5; wstrb = 2'b11; tick();
        idle(); read = 1'b1; raddr = 4'd9; tick();
        tick();
        @(posedge clk);
        #2 rst = 1'b1;
        read = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            checks++;
            if (rdata_w[i] !== 16'h0000 || rvalid_w[i] !== 1'b0) begin
                failures++;
                $display("FAIL async_clear dut%0d got=%0b/%h exp=0/0000", i, rvalid_w[i], rdata_w[i]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        for (int cyc = 0; cyc < 7; cyc++) tick();
        rst = 1'b1;
        #1;
        checks++;
        if (busy_w[0] !== 1'b1 || busy_w[1] !== 1'b1) begin
            failures++;
            $display("FAIL midclear_busy got=%0b%0b exp=11", busy_w[0], busy_w[1]);
        end
        @(negedge clk);
        rst = 1'b0;
        busy_cnt = 0;
        for (int cyc = 0; cyc < 22; cyc++) begin
            if (busy_w[0] === 1'b1) busy_cnt++;
            for (int i = 0; i < N; i++) begin
                checks++;
                if (busy_w[i] !== (clr_left[i] != 0) || rvalid_w[i] !== e_v[i]) begin
                    failures++;
                    $display("FAIL restart dut%0d cyc%0d got=%0b/%0b exp=%0b/%0b", i, cyc, busy_w[i], rvalid_w[i], clr_left[i] != 0, e_v[i]);
                end
                if (e_k[i] && e_v[i]) begin
                    checks++;
                    if (rdata_w[i] !== e_d[i]) begin
                        failures++;
                        $display("FAIL restart_rdata dut%0d cyc%0d got=%h exp=%h", i, cyc, rdata_w[i], e_d[i]);
                    end
                end
            end
            if (cyc == 18) begin
                checks++;
                if (rvalid_w[0] !== 1'b1 || rdata_w[0] !== 16'h0000) begin
                    failures++;
                    $display("FAIL restart_zero got=%0b/%h exp=1/0000", rvalid_w[0], rdata_w[0]);
                end
            end
            idle();
            if (cyc == 17) begin read = 1'b1; raddr = 4'd9; end
            tick();
        end
        checks++;
        if (busy_cnt != 16) begin
            failures++;
            $display("FAIL restart_len got=%0d exp=16", busy_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_strobe();
        test_collision();
        test_back_to_back();
        test_zero_strobe();
        test_random();
        test_reset_mid_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bram_sdp.md
Name: bram_sdp

Overview:
- Simple-dual-port inferred block RAM: one write port with byte strobes and one independent read port.
- Selectable read latency of 1 or 2 cycles, and a selectable read-during-write mode.
- A hardware clear sequencer zero-fills the array after reset.
- Replaces the single-port bram in CPU register/cache/scratch paths that need concurrent read and write plus a known initial state.

Parameters:
- memSize_p, 8, address width; depth is 2**memSize_p words.
- dataWidth_p, 16, word width in bits.
- byteWidth_p, 8, lane width; dataWidth_p must be an integer multiple (elaboration error otherwise).
- outReg_p, 0, 0 = 1-cycle read latency; 1 = extra output register, 2-cycle latency.
- rdwMode_p, 0, 0 = write-first (forward new bytes on same-address collision); 1 = read-first (old data).
- clearOnReset_p, 1, 1 = zero-fill array after reset; 0 = skip clear.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-high reset.
- write_i  in  1  write request.
- waddr_i  in  memSize_p  write address.
- wdata_i  in  dataWidth_p  write data.
- wstrb_i  in  dataWidth_p/byteWidth_p  per-lane write enable.
- read_i  in  1  read request.
- raddr_i  in  memSize_p  read address.
- rdata_o  out  dataWidth_p  read data.
- rvalid_o  out  1  one-cycle pulse aligned with new rdata_o.
- busy_o  out  1  clear in progress; requests ignored while high.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is asynchronous and active-high on reset_i.
  - Only control and output registers are reset; the array itself is never async-reset.
- Reset values:
  - rdata_o = 0, rvalid_o = 0, pipeline valid bits = 0, clear counter = 0.
  - busy_o = 1 if clearOnReset_p, else 0.
  - state = CLEAR if clearOnReset_p, else READY.
- FSM states:
  - CLEAR:
    - Each cycle writes all-zero to mem[cnt] and increments cnt.
    - When cnt = 2**memSize_p-1, that final write happens and the FSM goes to READY on the next edge.
    - Takes exactly 2**memSize_p cycles; busy_o drops on the first READY cycle.
    - write_i and read_i are dropped, not queued; rvalid_o stays 0.
  - READY: normal operation; remains here until reset.
- Reset asserted mid-clear or mid-read: FSM returns to CLEAR with cnt = 0 and the in-flight rvalid is cancelled; the clear restarts from address 0.
- Write (READY, write_i=1):
  - At the clock edge, for each lane k with wstrb_i[k]=1, mem[waddr_i] lane k is updated from wdata_i lane k.
  - Lanes with strobe 0 are unchanged.
  - write_i=1 with all strobes 0 is a no-op.
- Read (READY, read_i=1):
  - Samples raddr_i.
  - outReg_p=0: rdata_o/rvalid_o update on the next edge (latency 1).
  - outReg_p=1: one further edge (latency 2).
  - Back-to-back reads give one result per cycle, fully pipelined.
  - With no read, rvalid_o=0 and rdata_o holds its last value.
- Same-cycle read and write, raddr_i == waddr_i:
  - rdwMode_p=0: returned word has new bytes in strobed lanes and old bytes elsewhere.
  - rdwMode_p=1: returned word is entirely the pre-write contents.
  - Different addresses: no interaction.
- A write in cycle N is visible to any read issued in cycle N+1 or later, in either mode.
- Addresses are exactly memSize_p bits wide, so there is no out-of-range case and no wrap logic.

Decomposition:
- Package bram_pkg holds:
  - state enum {CLEAR, READY};
  - strobe-width function strbWidth(dataWidth, byteWidth);
  - RDW_WRITE_FIRST = 0 and RDW_READ_FIRST = 1 constants.
- One sub-module: bram_rdw_merge.
  - Combinational byte-lane mux.
  - Inputs: registered array data, registered collision flag, strobes and write data.
  - Instantiated only when rdwMode_p=0.
- The clear sequencer and output pipeline stay inline.

Test Plan:
- Clear: release reset with memSize_p=4, then read all 16 addresses. Required: busy_o high for exactly 16 cycles after reset release; every read returns 0x0000; requests issued while busy_o is high return no rvalid_o.
- Byte strobes:
  - Write 0xABCD to addr 3 with strb=11.
  - Then write 0x1200 to addr 3 with strb=10.
  - Read addr 3. Required: rdata_o = 0x12CD, rvalid_o after exactly 1 cycle (outReg_p=0) or 2 cycles (outReg_p=1).
- Collision:
  - mem[5]=0x1111.
  - Same cycle: write 0x2222 to addr 5 with strb=01, and read addr 5.
  - Required: 0x1122 with rdwMode_p=0; 0x1111 with rdwMode_p=1; a following read returns 0x1122 in both modes.
- Pipelining: reads of addresses 0,1,2,3 on consecutive cycles. Required: four consecutive rvalid_o pulses with data in the same order.
- Reset mid-clear: assert reset_i at cnt=7, then release. Required: rdata_o/rvalid_o clear asynchronously, busy_o stays high, and the full 2**memSize_p-cycle clear restarts at address 0.
- Zero strobe and no-clear: write_i with strb=00 leaves the word unchanged. With clearOnReset_p=0, busy_o is 0 immediately after reset and a write then read to addr 2 works on the first cycle.
